rename_map_ckpt_table: RTL and testbench
========================================

Name: rename_map_ckpt_table

Overview:
Superscalar register-rename map table for the OoO core. It sits between dispatch and the ROB/restore logic.
- Maps architectural to physical tags through NUM_READ_PORTS source lookups and NUM_RENAME_PORTS destination renames per cycle.
- Returns each renamed register's previous mapping so the ROB can free it later.
- Keeps a circular buffer of NUM_CHECKPOINTS map snapshots, which are saved on branches, released in order at commit, and restored on mispredict.

Parameters:
NUM_ARCH_REGS, 32, architectural registers
NUM_PHYS_REGS, 64, physical registers
NUM_READ_PORTS, 4, source lookup ports
NUM_RENAME_PORTS, 2, destination renames per cycle
NUM_CHECKPOINTS, 4, snapshot slots (power of 2)
ROB_INDEX_W, 6, ROB index width

Ports:
CLK  in  1  clock
nRST  in  1  synchronous active-low reset
rd_arch_tag  in  NUM_READ_PORTS x log2(NUM_ARCH_REGS)  source lookups
rd_phys_tag  out  NUM_READ_PORTS x log2(NUM_PHYS_REGS)  current mapping
rename_valid  in  NUM_RENAME_PORTS  per-port rename enable
rename_arch_tag  in  NUM_RENAME_PORTS x log2(NUM_ARCH_REGS)  destination arch reg
rename_phys_tag  in  NUM_RENAME_PORTS x log2(NUM_PHYS_REGS)  newly allocated phys reg
rename_old_phys_tag  out  NUM_RENAME_PORTS x log2(NUM_PHYS_REGS)  previous mapping
save_valid  in  1  take snapshot
save_slot  in  log2(NUM_RENAME_PORTS+1)  snapshot includes renames on ports < save_slot
save_ROB_index  in  ROB_INDEX_W  branch ROB index
save_ready  out  1  free slot exists
save_ckpt_id  out  log2(NUM_CHECKPOINTS)  slot the next save will use (tail)
restore_valid  in  1  mispredict restore
restore_ckpt_id  in  log2(NUM_CHECKPOINTS)  target slot
restore_ROB_index  in  ROB_INDEX_W  tag check
restore_success  out  1  restore accepted
release_valid  in  1  branch committed
release_ckpt_id  in  log2(NUM_CHECKPOINTS)  slot to free
release_error  out  1  release not on valid head
ckpt_count  out  log2(NUM_CHECKPOINTS)+1  occupied slots

Behaviour:
- Reset (nRST low at posedge CLK): working map entry i = i; all slots invalid; head = tail = 0; ckpt_count = 0; save_ready = 1. restore_success and release_error are 0 during reset.
- Reads: rd_phys_tag is combinational from the registered working map. Same-cycle renames are not forwarded; dispatch resolves intra-group dependences.
- Renames:
  - Applied at the next posedge, in port order.
  - Where ports share an arch tag, the highest port wins.
  - rename_old_phys_tag[k] is combinational. It equals the mapping after renames on ports < k this cycle, i.e. the intra-group chain.
- Save:
  - Accepted when save_valid and ckpt_count < NUM_CHECKPOINTS.
  - Slot tail is written with valid = 1, save_ROB_index, and the map after renames on ports < save_slot. Then tail++ mod NUM_CHECKPOINTS and count++.
  - Save while full is dropped with no state change. Dispatch must gate on save_ready.
  - Save and renames in the same cycle are legal.
- Restore:
  - Success requires slot restore_ckpt_id to be valid with matching ROB index.
  - On success the working map becomes the snapshot. That slot and all younger slots are invalidated, tail = restore_ckpt_id, and count is recomputed as (tail − head) mod N, using N when that value is 0 and the head slot is still valid.
  - Restore has the highest priority. All renames and saves in the same cycle are discarded. Release still applies unless it targets restore_ckpt_id, in which case it is dropped silently.
  - A failed restore causes no state change and restore_success = 0.
- Release:
  - When release_ckpt_id == head and the head slot is valid: the slot is invalidated, head++, count--.
  - Otherwise release_error = 1 for that cycle (combinational) and state is held.
- ckpt_count and save_ready are derived from registered state only.
- Asynchronous behaviour on nRST is illegal; reset takes effect only on a clock edge.

Decomposition:
- core_types_pkg gains: arch_reg_tag_t, phys_reg_tag_t, ROB_index_t, ckpt_id_t, and a map_snapshot_t struct (valid, ROB_index, array).
- One sub-module, rename_map_chain: a combinational intra-group chain producing rename_old_phys_tag and the per-prefix maps (post-port-k map) used by save_slot selection.

Test Plan:
1. Reset, then read arch tags 0/5/31 → phys 0/5/31; ckpt_count = 0; save_ready = 1.
2. Port0 renames r3→40 and port1 renames r3→41 in one cycle → old_phys = 3 and 40; the next-cycle read of r3 = 41.
3. Port0 renames r4→42, port1 renames r6→43, save_slot = 1, ROB index 9 → ckpt 0 holds r4 = 42, r6 = 6. Restore(0, 9) → r6 reads 6, restore_success = 1, ckpt_count = 0.
4. Four saves → save_ready = 0. A fifth save is ignored, with save_ckpt_id unchanged at 0.
5. Release id 1 while head = 0 → release_error = 1. Release 0 → head = 1, ckpt_count = 3.
6. Restore with wrong ROB index → restore_success = 0, map unchanged. Restore coincident with a rename of r2→50 → rename discarded, r2 reads the snapshot value.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared rename/checkpoint types: tag widths, map image and snapshot slot layout.
// Pure types and constants, no logic.
// No flow control here; consumers define their own handshakes.
package core_types_pkg;

    localparam int NUM_ARCH_REGS    = 32;
    localparam int NUM_PHYS_REGS    = 64;
    localparam int NUM_READ_PORTS   = 4;
    localparam int NUM_RENAME_PORTS = 2;
    localparam int NUM_CHECKPOINTS  = 4;
    localparam int ROB_INDEX_W      = 6;

    localparam int ARCH_TAG_W  = $clog2(NUM_ARCH_REGS);
    localparam int PHYS_TAG_W  = $clog2(NUM_PHYS_REGS);
    localparam int CKPT_ID_W   = $clog2(NUM_CHECKPOINTS);
    localparam int CKPT_CNT_W  = CKPT_ID_W + 1;
    localparam int SAVE_SLOT_W = $clog2(NUM_RENAME_PORTS + 1);

    typedef logic [ARCH_TAG_W-1:0]  arch_reg_tag_t;
    typedef logic [PHYS_TAG_W-1:0]  phys_reg_tag_t;
    typedef logic [ROB_INDEX_W-1:0] ROB_index_t;
    typedef logic [CKPT_ID_W-1:0]   ckpt_id_t;
    typedef logic [CKPT_CNT_W-1:0]  ckpt_cnt_t;
    typedef logic [SAVE_SLOT_W-1:0] save_slot_t;

    // Whole arch->phys map, indexed by arch tag.
    typedef logic [NUM_ARCH_REGS-1:0][PHYS_TAG_W-1:0] map_t;

    typedef struct packed {
        logic       valid;
        ROB_index_t ROB_index;
        map_t       map;
    } map_snapshot_t;

endpackage

// File: rtl/rename_map_chain.sv
// Intra-group rename chain: previous mapping per port and the map after each port prefix.
// Purely combinational, zero cycles.
// No backpressure; evaluates every cycle from the registered base map.
module rename_map_chain
    import core_types_pkg::*;
(
    input  map_t                        base_map,
    input  logic [NUM_RENAME_PORTS-1:0] rename_valid,
    input  arch_reg_tag_t               rename_arch_tag [NUM_RENAME_PORTS],
    input  phys_reg_tag_t               rename_phys_tag [NUM_RENAME_PORTS],
    output phys_reg_tag_t               old_phys_tag    [NUM_RENAME_PORTS],
    output map_t                        prefix_map      [NUM_RENAME_PORTS+1]
);

    // prefix_map[k] is the map after renames on ports < k; later ports overwrite earlier ones.
    always_comb begin
        map_t m;
        m             = base_map;
        prefix_map[0] = base_map;
        for (int k = 0; k < NUM_RENAME_PORTS; k++) begin
            old_phys_tag[k] = m[rename_arch_tag[k]];
            if (rename_valid[k])
                m[rename_arch_tag[k]] = rename_phys_tag[k];
            prefix_map[k+1] = m;
        end
    end

endmodule

// File: rtl/rename_map_ckpt_table.sv
// Rename map table with a circular buffer of branch snapshots (save/release/restore).
// Reads and old-mapping returns are combinational; map and slot updates land at the next CLK edge.
// No stall: a save while full is dropped, so dispatch must gate saves on save_ready.
module rename_map_ckpt_table
    import core_types_pkg::*;
(
    input  logic                        CLK,
    input  logic                        nRST,
    input  arch_reg_tag_t               rd_arch_tag         [NUM_READ_PORTS],
    output phys_reg_tag_t               rd_phys_tag         [NUM_READ_PORTS],
    input  logic [NUM_RENAME_PORTS-1:0] rename_valid,
    input  arch_reg_tag_t               rename_arch_tag     [NUM_RENAME_PORTS],
    input  phys_reg_tag_t               rename_phys_tag     [NUM_RENAME_PORTS],
    output phys_reg_tag_t               rename_old_phys_tag [NUM_RENAME_PORTS],
    input  logic                        save_valid,
    input  save_slot_t                  save_slot,
    input  ROB_index_t                  save_ROB_index,
    output logic                        save_ready,
    output ckpt_id_t                    save_ckpt_id,
    input  logic                        restore_valid,
    input  ckpt_id_t                    restore_ckpt_id,
    input  ROB_index_t                  restore_ROB_index,
    output logic                        restore_success,
    input  logic                        release_valid,
    input  ckpt_id_t                    release_ckpt_id,
    output logic                        release_error,
    output ckpt_cnt_t                   ckpt_count
);

    map_t                       work_map;
    map_snapshot_t              ckpt [NUM_CHECKPOINTS];
    ckpt_id_t                   head;
    ckpt_id_t                   tail;
    map_t                       prefix_map [NUM_RENAME_PORTS+1];
    ckpt_cnt_t                  count;
    save_slot_t                 slot_sel;
    logic                       restore_ok;
    logic                       release_drop;
    logic                       release_hit;
    logic                       release_ok;
    logic                       save_acc;
    logic [NUM_CHECKPOINTS-1:0] kill_mask;

    rename_map_chain u_chain (
        .base_map        (work_map),
        .rename_valid    (rename_valid),
        .rename_arch_tag (rename_arch_tag),
        .rename_phys_tag (rename_phys_tag),
        .old_phys_tag    (rename_old_phys_tag),
        .prefix_map      (prefix_map)
    );

    always_comb begin
        for (int i = 0; i < NUM_READ_PORTS; i++)
            rd_phys_tag[i] = work_map[rd_arch_tag[i]];
    end

    // head == tail is ambiguous; the head slot's valid bit tells full from empty.
    always_comb begin
        ckpt_id_t diff;
        diff  = tail - head;
        count = {1'b0, diff};
        if (diff == '0 && ckpt[head].valid)
            count = CKPT_CNT_W'(NUM_CHECKPOINTS);
    end

    assign ckpt_count   = count;
    assign save_ready   = (count < CKPT_CNT_W'(NUM_CHECKPOINTS));
    assign save_ckpt_id = tail;

    assign restore_ok   = restore_valid && ckpt[restore_ckpt_id].valid
                          && (ckpt[restore_ckpt_id].ROB_index == restore_ROB_index);
    assign release_drop = restore_ok && (release_ckpt_id == restore_ckpt_id);
    assign release_hit  = (release_ckpt_id == head) && ckpt[head].valid;
    assign release_ok   = release_valid && release_hit && !release_drop;
    assign save_acc     = save_valid && save_ready && !restore_ok;

    assign restore_success = nRST && restore_ok;
    assign release_error   = nRST && release_valid && !release_hit && !release_drop;

    assign slot_sel = (save_slot > SAVE_SLOT_W'(NUM_RENAME_PORTS))
                      ? SAVE_SLOT_W'(NUM_RENAME_PORTS) : save_slot;

    // Kill the restored slot and every valid slot younger than it (further from head).
    always_comb begin
        ckpt_id_t age_i;
        ckpt_id_t age_r;
        age_r = restore_ckpt_id - head;
        for (int i = 0; i < NUM_CHECKPOINTS; i++) begin
            age_i        = ckpt_id_t'(i) - head;
            kill_mask[i] = restore_ok && ckpt[i].valid && (age_i >= age_r);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++)
                work_map[i] <= PHYS_TAG_W'(i);
            for (int i = 0; i < NUM_CHECKPOINTS; i++)
                ckpt[i] <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            if (restore_ok)
                work_map <= ckpt[restore_ckpt_id].map;
            else
                work_map <= prefix_map[NUM_RENAME_PORTS];

            for (int i = 0; i < NUM_CHECKPOINTS; i++)
                if (kill_mask[i])
                    ckpt[i].valid <= 1'b0;

            if (release_ok) begin
                ckpt[head].valid <= 1'b0;
                head             <= head + 1'b1;
            end

            if (save_acc) begin
                ckpt[tail].valid     <= 1'b1;
                ckpt[tail].ROB_index <= save_ROB_index;
                ckpt[tail].map       <= prefix_map[slot_sel];
                tail                 <= tail + 1'b1;
            end

            if (restore_ok)
                tail <= restore_ckpt_id;
        end
    end

endmodule

// File: tb/tb_rename_map_ckpt_table.sv
// Directed bench for the rename map / checkpoint table with hand-computed expectations.
module tb_rename_map_ckpt_table;
    import core_types_pkg::*;

    logic                        CLK = 1'b0;
    logic                        nRST;
    arch_reg_tag_t               rd_arch_tag         [NUM_READ_PORTS];
    phys_reg_tag_t               rd_phys_tag         [NUM_READ_PORTS];
    logic [NUM_RENAME_PORTS-1:0] rename_valid;
    arch_reg_tag_t               rename_arch_tag     [NUM_RENAME_PORTS];
    phys_reg_tag_t               rename_phys_tag     [NUM_RENAME_PORTS];
    phys_reg_tag_t               rename_old_phys_tag [NUM_RENAME_PORTS];
    logic                        save_valid;
    save_slot_t                  save_slot;
    ROB_index_t                  save_ROB_index;
    logic                        save_ready;
    ckpt_id_t                    save_ckpt_id;
    logic                        restore_valid;
    ckpt_id_t                    restore_ckpt_id;
    ROB_index_t                  restore_ROB_index;
    logic                        restore_success;
    logic                        release_valid;
    ckpt_id_t                    release_ckpt_id;
    logic                        release_error;
    ckpt_cnt_t                   ckpt_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    rename_map_ckpt_table dut (
        .CLK                 (CLK),
        .nRST                (nRST),
        .rd_arch_tag         (rd_arch_tag),
        .rd_phys_tag         (rd_phys_tag),
        .rename_valid        (rename_valid),
        .rename_arch_tag     (rename_arch_tag),
        .rename_phys_tag     (rename_phys_tag),
        .rename_old_phys_tag (rename_old_phys_tag),
        .save_valid          (save_valid),
        .save_slot           (save_slot),
        .save_ROB_index      (save_ROB_index),
        .save_ready          (save_ready),
        .save_ckpt_id        (save_ckpt_id),
        .restore_valid       (restore_valid),
        .restore_ckpt_id     (restore_ckpt_id),
        .restore_ROB_index   (restore_ROB_index),
        .restore_success     (restore_success),
        .release_valid       (release_valid),
        .release_ckpt_id     (release_ckpt_id),
        .release_error       (release_error),
        .ckpt_count          (ckpt_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        rename_valid      = '0;
        save_valid        = 1'b0;
        save_slot         = '0;
        save_ROB_index    = '0;
        restore_valid     = 1'b0;
        restore_ckpt_id   = '0;
        restore_ROB_index = '0;
        release_valid     = 1'b0;
        release_ckpt_id   = '0;
        for (int k = 0; k < NUM_RENAME_PORTS; k++) begin
            rename_arch_tag[k] = '0;
            rename_phys_tag[k] = '0;
        end
    endtask

    // Advance one edge, then return 1 time unit later with inputs idle.
    task automatic step();
        @(posedge CLK);
        #1;
        idle();
        #1;
    endtask

    task automatic rd(input int a0, input int a1, input int a2, input int a3);
        rd_arch_tag[0] = ARCH_TAG_W'(a0);
        rd_arch_tag[1] = ARCH_TAG_W'(a1);
        rd_arch_tag[2] = ARCH_TAG_W'(a2);
        rd_arch_tag[3] = ARCH_TAG_W'(a3);
        #1;
    endtask

    task automatic ren(input int k, input int a, input int p);
        rename_valid[k]    = 1'b1;
        rename_arch_tag[k] = ARCH_TAG_W'(a);
        rename_phys_tag[k] = PHYS_TAG_W'(p);
    endtask

    task automatic save(input int slot, input int rob);
        save_valid     = 1'b1;
        save_slot      = SAVE_SLOT_W'(slot);
        save_ROB_index = ROB_INDEX_W'(rob);
    endtask

    task automatic restore(input int id, input int rob);
        restore_valid     = 1'b1;
        restore_ckpt_id   = CKPT_ID_W'(id);
        restore_ROB_index = ROB_INDEX_W'(rob);
    endtask

    task automatic rel(input int id);
        release_valid   = 1'b1;
        release_ckpt_id = CKPT_ID_W'(id);
    endtask

    initial begin
        nRST = 1'b0;
        idle();
        rd(0, 0, 0, 0);
        restore(0, 0);
        rel(2);
        #1;
        chk("rst_restore_success", restore_success, 0);
        chk("rst_release_error", release_error, 0);
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        idle();
        #1;

        // 1: identity map after reset
        rd(0, 5, 31, 17);
        chk("rst_rd0", rd_phys_tag[0], 0);
        chk("rst_rd5", rd_phys_tag[1], 5);
        chk("rst_rd31", rd_phys_tag[2], 31);
        chk("rst_rd17", rd_phys_tag[3], 17);
        chk("rst_count", ckpt_count, 0);
        chk("rst_save_ready", save_ready, 1);
        chk("rst_save_id", save_ckpt_id, 0);

        // 2: same arch tag on both ports, highest port wins
        ren(0, 3, 40);
        ren(1, 3, 41);
        #1;
        chk("chain_old0", rename_old_phys_tag[0], 3);
        chk("chain_old1", rename_old_phys_tag[1], 40);
        rd(3, 0, 0, 0);
        chk("no_forward_r3", rd_phys_tag[0], 3);
        step();
        rd(3, 0, 0, 0);
        chk("r3_after", rd_phys_tag[0], 41);

        // 3: save including only port 0, then restore it
        ren(0, 4, 42);
        ren(1, 6, 43);
        save(1, 9);
        step();
        rd(4, 6, 3, 0);
        chk("s3_r4", rd_phys_tag[0], 42);
        chk("s3_r6", rd_phys_tag[1], 43);
        chk("s3_count", ckpt_count, 1);
        chk("s3_save_id", save_ckpt_id, 1);
        restore(0, 9);
        #1;
        chk("s3_restore_ok", restore_success, 1);
        step();
        rd(4, 6, 3, 0);
        chk("s3_rest_r4", rd_phys_tag[0], 42);
        chk("s3_rest_r6", rd_phys_tag[1], 6);
        chk("s3_rest_r3", rd_phys_tag[2], 41);
        chk("s3_rest_count", ckpt_count, 0);
        chk("s3_rest_tail", save_ckpt_id, 0);

        // 4: fill all four slots with varied save_slot prefixes
        save(0, 1);
        step();
        ren(0, 7, 44);
        ren(1, 8, 45);
        save(2, 2);
        step();
        ren(0, 7, 46);
        save(0, 3);
        step();
        chk("s4_count3", ckpt_count, 3);
        save(0, 4);
        step();
        chk("s4_count4", ckpt_count, 4);
        chk("s4_full_ready", save_ready, 0);
        chk("s4_full_id", save_ckpt_id, 0);
        save(0, 5);
        step();
        chk("s4_drop_count", ckpt_count, 4);
        chk("s4_drop_id", save_ckpt_id, 0);
        rd(7, 8, 0, 0);
        chk("s4_r7", rd_phys_tag[0], 46);
        chk("s4_r8", rd_phys_tag[1], 45);

        // 5: release out of order then in order
        rel(1);
        #1;
        chk("s5_rel_err", release_error, 1);
        step();
        chk("s5_err_count", ckpt_count, 4);
        rel(0);
        #1;
        chk("s5_rel_ok", release_error, 0);
        step();
        chk("s5_count", ckpt_count, 3);
        chk("s5_ready", save_ready, 1);

        // 6: bad ROB index, then restore with rename and a release of the head
        restore(2, 7);
        #1;
        chk("s6_bad_rob", restore_success, 0);
        step();
        rd(7, 0, 0, 0);
        chk("s6_bad_r7", rd_phys_tag[0], 46);
        chk("s6_bad_count", ckpt_count, 3);
        restore(2, 3);
        ren(0, 2, 50);
        rel(1);
        #1;
        chk("s6_restore_ok", restore_success, 1);
        chk("s6_rel_noerr", release_error, 0);
        step();
        rd(2, 7, 8, 6);
        chk("s6_r2", rd_phys_tag[0], 2);
        chk("s6_r7", rd_phys_tag[1], 44);
        chk("s6_r8", rd_phys_tag[2], 45);
        chk("s6_r6", rd_phys_tag[3], 6);
        chk("s6_count", ckpt_count, 0);
        chk("s6_tail", save_ckpt_id, 2);
        restore(3, 4);
        #1;
        chk("s6_dead_slot", restore_success, 0);
        idle();
        rel(2);
        #1;
        chk("s6_empty_rel", release_error, 1);
        idle();
        #1;

        // Release of the slot being restored is dropped without error
        save(0, 10);
        step();
        chk("s7_count", ckpt_count, 1);
        restore(2, 10);
        rel(2);
        #1;
        chk("s7_restore_ok", restore_success, 1);
        chk("s7_drop_noerr", release_error, 0);
        step();
        chk("s7_count0", ckpt_count, 0);
        chk("s7_tail", save_ckpt_id, 2);
        chk("s7_ready", save_ready, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
